// File: rtl/alu_issue.sv
// Decode/issue stage feeding the ALU: decodes a MIPS instruction into a one-hot
// ALU select plus operands, held in a main output register backed by one skid entry.
module alu_issue (
  input  logic        clk,
  input  logic        resetn,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] inst,
  input  logic [31:0] rs_value,
  input  logic [31:0] rt_value,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [11:0] alu_control,
  output logic [31:0] alu_src1,
  output logic [31:0] alu_src2,
  output logic [4:0]  dest,
  output logic        illegal
);

  localparam logic [11:0] ALU_ADD  = 12'h800;
  localparam logic [11:0] ALU_SUB  = 12'h400;
  localparam logic [11:0] ALU_SLT  = 12'h200;
  localparam logic [11:0] ALU_SLTU = 12'h100;
  localparam logic [11:0] ALU_AND  = 12'h080;
  localparam logic [11:0] ALU_NOR  = 12'h040;
  localparam logic [11:0] ALU_OR   = 12'h020;
  localparam logic [11:0] ALU_XOR  = 12'h010;
  localparam logic [11:0] ALU_SLL  = 12'h008;
  localparam logic [11:0] ALU_SRL  = 12'h004;
  localparam logic [11:0] ALU_SRA  = 12'h002;
  localparam logic [11:0] ALU_LUI  = 12'h001;

  typedef struct packed {
    logic [11:0] ctrl;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  dest;
    logic        illegal;
  } entry_t;

  logic [5:0]  op;
  logic [5:0]  funct;
  logic [4:0]  rt;
  logic [4:0]  rd;
  logic [4:0]  sa;
  logic [31:0] imm_se;
  logic [31:0] imm_ze;
  logic        unused_rs;

  assign op        = inst[31:26];
  assign rt        = inst[20:16];
  assign rd        = inst[15:11];
  assign sa        = inst[10:6];
  assign funct     = inst[5:0];
  assign imm_se    = {{16{inst[15]}}, inst[15:0]};
  assign imm_ze    = {16'd0, inst[15:0]};
  assign unused_rs = ^inst[25:21];

  entry_t dec;

  always_comb begin
    dec         = '0;
    dec.illegal = 1'b1;
    case (op)
      6'h00: begin
        case (funct)
          6'h21:        dec.ctrl = ALU_ADD;
          6'h23:        dec.ctrl = ALU_SUB;
          6'h2A:        dec.ctrl = ALU_SLT;
          6'h2B:        dec.ctrl = ALU_SLTU;
          6'h24:        dec.ctrl = ALU_AND;
          6'h27:        dec.ctrl = ALU_NOR;
          6'h25:        dec.ctrl = ALU_OR;
          6'h26:        dec.ctrl = ALU_XOR;
          6'h04, 6'h00: dec.ctrl = ALU_SLL;
          6'h06, 6'h02: dec.ctrl = ALU_SRL;
          6'h07, 6'h03: dec.ctrl = ALU_SRA;
          default:      dec.ctrl = '0;
        endcase
        // Constant-shift functs (00/02/03) take the shift amount from sa.
        if (dec.ctrl != '0) begin
          dec.illegal = 1'b0;
          dec.src1    = (funct[5:2] == 4'b0000) ? {27'd0, sa} : rs_value;
          dec.src2    = rt_value;
          dec.dest    = rd;
        end
      end
      6'h09, 6'h23: begin
        dec = '{ctrl: ALU_ADD, src1: rs_value, src2: imm_se, dest: rt, illegal: 1'b0};
      end
      6'h2B: begin
        dec = '{ctrl: ALU_ADD, src1: rs_value, src2: imm_se, dest: 5'd0, illegal: 1'b0};
      end
      6'h0A: begin
        dec = '{ctrl: ALU_SLT, src1: rs_value, src2: imm_se, dest: rt, illegal: 1'b0};
      end
      6'h0B: begin
        dec = '{ctrl: ALU_SLTU, src1: rs_value, src2: imm_se, dest: rt, illegal: 1'b0};
      end
      6'h0C: begin
        dec = '{ctrl: ALU_AND, src1: rs_value, src2: imm_ze, dest: rt, illegal: 1'b0};
      end
      6'h0D: begin
        dec = '{ctrl: ALU_OR, src1: rs_value, src2: imm_ze, dest: rt, illegal: 1'b0};
      end
      6'h0E: begin
        dec = '{ctrl: ALU_XOR, src1: rs_value, src2: imm_ze, dest: rt, illegal: 1'b0};
      end
      6'h0F: begin
        dec = '{ctrl: ALU_LUI, src1: 32'd0, src2: imm_ze, dest: rt, illegal: 1'b0};
      end
      default: ;
    endcase
  end

  entry_t main_q, main_d;
  entry_t skid_q, skid_d;
  logic   main_valid_q, main_valid_d;
  logic   skid_valid_q, skid_valid_d;
  logic   accept;

  assign accept = in_valid & ~skid_valid_q;

  // Skid always refills main before any new entry, which keeps issue order intact.
  always_comb begin
    main_d       = main_q;
    main_valid_d = main_valid_q;
    skid_d       = skid_q;
    skid_valid_d = skid_valid_q;
    if (!main_valid_q || out_ready) begin
      if (skid_valid_q) begin
        main_d       = skid_q;
        main_valid_d = 1'b1;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        main_d       = dec;
        main_valid_d = 1'b1;
      end else begin
        main_valid_d = 1'b0;
      end
    end else if (accept) begin
      skid_d       = dec;
      skid_valid_d = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      main_q       <= '0;
      main_valid_q <= 1'b0;
      skid_q       <= '0;
      skid_valid_q <= 1'b0;
    end else begin
      main_q       <= main_d;
      main_valid_q <= main_valid_d;
      skid_q       <= skid_d;
      skid_valid_q <= skid_valid_d;
    end
  end

  assign in_ready    = ~skid_valid_q;
  assign out_valid   = main_valid_q;
  assign alu_control = main_q.ctrl;
  assign alu_src1    = main_q.src1;
  assign alu_src2    = main_q.src2;
  assign dest        = main_q.dest;
  assign illegal     = main_q.illegal;

endmodule

// File: tb/tb_alu_issue.sv
// Scoreboard bench for alu_issue: the driver pushes reference-decoded entries on
// accept, an independent monitor pops and compares whenever the DUT issues.
module tb_alu_issue;

  logic        clk = 1'b0;
  logic        resetn;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] inst;
  logic [31:0] rs_value;
  logic [31:0] rt_value;
  logic        out_valid;
  logic        out_ready;
  logic [11:0] alu_control;
  logic [31:0] alu_src1;
  logic [31:0] alu_src2;
  logic [4:0]  dest;
  logic        illegal;

  alu_issue dut (
    .clk         (clk),
    .resetn      (resetn),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .inst        (inst),
    .rs_value    (rs_value),
    .rt_value    (rt_value),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .alu_control (alu_control),
    .alu_src1    (alu_src1),
    .alu_src2    (alu_src2),
    .dest        (dest),
    .illegal     (illegal)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [11:0] ctrl;
    logic [31:0] src1;
    logic [31:0] src2;
    logic [4:0]  dest;
    logic        ill;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;
  bit   mon_en = 1'b0;

  // Operation index k selects alu_control bit 11-k (add=0 ... lui=11);
  // kind picks the operand pattern: 0 rs/rt, 1 sa/rt, 2 rs/SE, 3 rs/ZE, 4 0/ZE.
  function automatic exp_t refDecode(input logic [31:0] w, input logic [31:0] a,
                                     input logic [31:0] b);
    exp_t        e;
    int          k;
    int          kind;
    logic [4:0]  d;
    logic [31:0] se;
    logic [31:0] ze;
    k    = -1;
    kind = 0;
    se   = {{16{w[15]}}, w[15:0]};
    ze   = {16'd0, w[15:0]};
    d    = w[15:11];
    if (w[31:26] == 6'h00) begin
      case (w[5:0])
        6'h21: k = 0;
        6'h23: k = 1;
        6'h2A: k = 2;
        6'h2B: k = 3;
        6'h24: k = 4;
        6'h27: k = 5;
        6'h25: k = 6;
        6'h26: k = 7;
        6'h04: k = 8;
        6'h06: k = 9;
        6'h07: k = 10;
        6'h00: begin k = 8;  kind = 1; end
        6'h02: begin k = 9;  kind = 1; end
        6'h03: begin k = 10; kind = 1; end
        default: k = -1;
      endcase
    end else begin
      d = w[20:16];
      case (w[31:26])
        6'h09, 6'h23: begin k = 0;  kind = 2; end
        6'h2B:        begin k = 0;  kind = 2; d = 5'd0; end
        6'h0A:        begin k = 2;  kind = 2; end
        6'h0B:        begin k = 3;  kind = 2; end
        6'h0C:        begin k = 4;  kind = 3; end
        6'h0D:        begin k = 6;  kind = 3; end
        6'h0E:        begin k = 7;  kind = 3; end
        6'h0F:        begin k = 11; kind = 4; end
        default:      k = -1;
      endcase
    end
    e = '0;
    if (k < 0) begin
      e.ill = 1'b1;
    end else begin
      e.ctrl = 12'h001 << (11 - k);
      e.dest = d;
      case (kind)
        0: begin e.src1 = a;                 e.src2 = b;  end
        1: begin e.src1 = {27'd0, w[10:6]};  e.src2 = b;  end
        2: begin e.src1 = a;                 e.src2 = se; end
        3: begin e.src1 = a;                 e.src2 = ze; end
        default: begin e.src1 = 32'd0;       e.src2 = ze; end
      endcase
    end
    return e;
  endfunction

  function automatic logic [31:0] randInst();
    logic [5:0]  rfn [14] = '{6'h21, 6'h23, 6'h2A, 6'h2B, 6'h24, 6'h27, 6'h25,
                              6'h26, 6'h04, 6'h06, 6'h07, 6'h00, 6'h02, 6'h03};
    logic [5:0]  iop [9]  = '{6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0E, 6'h0F,
                              6'h23, 6'h2B};
    logic [31:0] w;
    w = $urandom;
    case ($urandom_range(0, 3))
      0, 1: begin
        w[31:26] = 6'h00;
        if ($urandom_range(0, 4) != 0) w[5:0] = rfn[$urandom_range(0, 13)];
      end
      2:       w[31:26] = iop[$urandom_range(0, 8)];
      default: ;
    endcase
    return w;
  endfunction

  task automatic checkOutput(input string name, input logic [95:0] act,
                             input logic [95:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [31:0] i, input logic [31:0] a,
                               input logic [31:0] b, input logic ordy, output bit acc);
    @(negedge clk);
    in_valid  = v;
    inst      = i;
    rs_value  = a;
    rt_value  = b;
    out_ready = ordy;
    #4;
    acc = v && in_ready;
    if (acc) exp_q.push_back(refDecode(i, a, b));
  endtask

  // Monitor: runs after the driver sets inputs but before the expected entries
  // of the upcoming edge are pushed, so queue size equals DUT occupancy.
  initial begin
    forever begin
      @(negedge clk);
      #3;
      if (mon_en) begin
        checkOutput("out_valid", out_valid, exp_q.size() > 0);
        checkOutput("in_ready", in_ready, exp_q.size() < 2);
        if (out_valid && exp_q.size() > 0) begin
          checkOutput("entry", {alu_control, alu_src1, alu_src2, dest, illegal}, exp_q[0]);
          if (out_ready) void'(exp_q.pop_front());
        end
      end
    end
  end

  initial begin
    bit acc;
    resetn    = 1'b0;
    in_valid  = 1'b0;
    inst      = 32'd0;
    rs_value  = 32'd0;
    rt_value  = 32'd0;
    out_ready = 1'b0;
    #12;
    checkOutput("reset_out_valid", out_valid, 0);
    checkOutput("reset_in_ready", in_ready, 1);
    checkOutput("reset_fields", {alu_control, alu_src1, alu_src2, dest, illegal}, 0);
    #1 resetn = 1'b1;
    mon_en = 1'b1;

    applyStimulus(1, 32'h00221821, 32'd5, 32'd7, 1, acc);
    applyStimulus(1, 32'h00031100, 32'd0, 32'h80000001, 1, acc);
    applyStimulus(1, 32'h3C051234, 32'd0, 32'd0, 1, acc);
    applyStimulus(1, 32'h2424FFFF, 32'h10, 32'd0, 1, acc);
    applyStimulus(1, 32'h3024FFFF, 32'h10, 32'd0, 1, acc);
    applyStimulus(1, 32'hAC240008, 32'h10, 32'd0, 1, acc);
    applyStimulus(1, 32'hFC000000, 32'h10, 32'h20, 1, acc);
    repeat (3) applyStimulus(0, 32'd0, 32'd0, 32'd0, 1, acc);

    // Backpressure: A held in main, B in skid, C stalled until the ALU drains.
    applyStimulus(1, 32'h00221821, 32'd1, 32'd2, 0, acc);
    checkOutput("bp_accept_a", acc, 1);
    applyStimulus(1, 32'h00221823, 32'd3, 32'd4, 0, acc);
    checkOutput("bp_accept_b", acc, 1);
    applyStimulus(1, 32'h00221826, 32'd5, 32'd6, 0, acc);
    checkOutput("bp_stall_c", acc, 0);
    applyStimulus(1, 32'h00221826, 32'd5, 32'd6, 0, acc);
    checkOutput("bp_stall_c_again", acc, 0);
    acc = 1'b0;
    for (int t = 0; t < 10 && !acc; t++)
      applyStimulus(1, 32'h00221826, 32'd5, 32'd6, 1, acc);
    checkOutput("bp_accept_c", acc, 1);
    repeat (3) applyStimulus(0, 32'd0, 32'd0, 32'd0, 1, acc);

    // Fill main and skid, then reset mid-cycle.
    applyStimulus(1, 32'h00A63020, 32'd9, 32'd9, 0, acc);
    applyStimulus(1, 32'h34A7FFFF, 32'd9, 32'd9, 0, acc);
    @(posedge clk);
    #1;
    checkOutput("full_in_ready", in_ready, 0);
    in_valid = 1'b0;
    resetn   = 1'b0;
    #1;
    checkOutput("midreset_out_valid", out_valid, 0);
    checkOutput("midreset_in_ready", in_ready, 1);
    checkOutput("midreset_fields", {alu_control, alu_src1, alu_src2, dest, illegal}, 0);
    exp_q.delete();
    #1 resetn = 1'b1;
    repeat (2) applyStimulus(0, 32'd0, 32'd0, 32'd0, 1, acc);

    for (int n = 0; n < 400; n++) begin
      logic [31:0] a;
      a = ($urandom_range(0, 3) == 0) ? 32'($urandom_range(0, 16)) : $urandom;
      applyStimulus($urandom_range(0, 3) != 0, randInst(), a, $urandom,
                    $urandom_range(0, 3) != 0, acc);
    end

    for (int t = 0; t < 20 && exp_q.size() > 0; t++)
      applyStimulus(0, 32'd0, 32'd0, 32'd0, 1, acc);
    checkOutput("drain_empty", exp_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
